// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI responder.
//   SPI_MODE0..SPI_MODE3 : {CPOL, CPHA} encodings of the four SPI modes
//   CPOL_BIT / CPHA_BIT  : bit positions inside a 2-bit mode value
//   SPI_DATA_W           : default word length
//   spi_state_e          : frame state (IDLE / ACTIVE)
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-stage input synchronizer with edge pulses.
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   d_i          : asynchronous input pin
//   q_o          : synchronized level
//   rise_o       : one-cycle pulse on a synchronized 0->1 transition
//   fall_o       : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL sets the level the chain assumes during reset.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, all four modes, oversampled on sys_clk.
//   sys_clk, sys_rst          : system clock, asynchronous active-high reset
//   spi_mode                  : {CPOL, CPHA}, latched at the start of a frame
//   tx_data/tx_valid/tx_ready : valid/ready write port of the TX holding register
//   rx_data/rx_valid          : last received word, one-cycle update pulse
//   tx_underrun               : pulse when a word begins with nothing to send
//   frame_err                 : pulse when chip select rises mid-word
//   spi_busy                  : frame in progress (exposes the FSM state)
//   spi_csn/spi_clk/spi_mosi  : SPI pins from the master
//   spi_miso/spi_miso_oe      : SPI data out and its output enable
// Handshake: a tx_data word is taken in any cycle where tx_valid and
// tx_ready are both high; tx_valid is ignored while tx_ready is low.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              spi_busy,
  input  logic              spi_csn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic clk_rise, clk_fall, clk_lvl_unused;
  logic csn_rise, csn_fall, csn_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_clk),
    .q_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  // Chip select resets to "low": a frame still in progress at reset release
  // produces no fall, so ACTIVE is reachable only after csn is seen high.
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csn (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_csn),
    .q_o(csn_lvl_unused), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q, tx_shift_q, hold_q, rx_data_q;
  logic              hold_full_q, rx_valid_q, underrun_q, frame_err_q, miso_q;
  logic              underrun_pend_q;

  // FSM
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (csn_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (csn_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic active, csn_start, csn_end;
  logic lead_edge, trail_edge, sample_edge, shift_edge, last_bit, wrap;
  logic word_start, start_empty;
  logic [DATA_W-1:0] start_word, rx_next;

  assign active     = (state_q == ST_ACTIVE);
  assign csn_start  = (state_q == ST_IDLE) & csn_fall;
  assign csn_end    = active & csn_rise;

  // Leading edge leaves the CPOL idle level, trailing edge returns to it.
  assign lead_edge  = mode_q[CPOL_BIT] ? clk_fall : clk_rise;
  assign trail_edge = mode_q[CPOL_BIT] ? clk_rise : clk_fall;
  assign sample_edge = active & ~csn_rise & (mode_q[CPHA_BIT] ? trail_edge : lead_edge);
  assign shift_edge  = active & ~csn_rise & (mode_q[CPHA_BIT] ? lead_edge : trail_edge);

  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign wrap       = sample_edge & last_bit;
  assign word_start = csn_start | wrap;

  // Word source at word start: holding register, else a same-cycle tx_valid
  // (tx_ready is high whenever the register is empty), else zeros.
  assign start_word  = hold_full_q ? hold_q : (tx_valid ? tx_data : '0);
  assign start_empty = ~hold_full_q & ~tx_valid;
  assign rx_next     = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q          <= '0;
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      underrun_q      <= 1'b0;
      underrun_pend_q <= 1'b0;
      frame_err_q     <= 1'b0;
      miso_q          <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Holding register: drained at word start, otherwise filled on handshake.
      // A handshake coinciding with word start bypasses the register.
      if (word_start && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (tx_valid && !hold_full_q && !word_start) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (csn_start) begin
        mode_q          <= spi_mode;
        bit_cnt_q       <= '0;
        rx_shift_q      <= '0;
        underrun_q      <= start_empty;
        underrun_pend_q <= 1'b0;
        // CPHA=0 presents the MSB before the first clock edge.
        if (spi_mode[CPHA_BIT]) begin
          tx_shift_q <= start_word;
        end else begin
          tx_shift_q <= start_word << 1;
          miso_q     <= start_word[DATA_W-1];
        end
      end else if (csn_end) begin
        frame_err_q     <= (bit_cnt_q != '0);
        bit_cnt_q       <= '0;
        rx_shift_q      <= '0;
        tx_shift_q      <= '0;
        miso_q          <= 1'b0;
        underrun_pend_q <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift_q <= rx_next;
          if (last_bit) begin
            bit_cnt_q  <= '0;
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
          // An empty word loaded at a wrap is reported only once its first
          // bit is exchanged, so a frame ending on a word boundary is clean.
          if (bit_cnt_q == '0 && underrun_pend_q) begin
            underrun_q      <= 1'b1;
            underrun_pend_q <= 1'b0;
          end
        end
        // At a wrap the full next word is loaded; the following shift edge
        // presents its MSB in both CPHA settings.
        if (wrap) begin
          tx_shift_q      <= start_word;
          underrun_pend_q <= start_empty;
        end else if (shift_edge) begin
          miso_q     <= tx_shift_q[DATA_W-1];
          tx_shift_q <= tx_shift_q << 1;
        end
      end
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;
  assign spi_busy    = active;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = active;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the far end of the 16-bit SPI master link: receives words on `spi_mosi`, returns words on `spi_miso`, and serves all four SPI modes. Fully synchronous to `sys_clk`; the SPI pins are oversampled through input synchronizers. It sits between the SPI pins and the user logic, with a ready/valid transmit holding register and a pulsed receive output.

## Interface
- `DATA_W`, 16, word length in bits, MSB first.
- `SYNC_STAGES`, 2, flip-flop stages on each SPI input (minimum 2).

- `sys_clk`  in  1  system clock, 50 MHz nominal.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `spi_mode`  in  2  bit 1 = CPOL, bit 0 = CPHA. Latched on the synchronized `spi_csn` falling edge.
- `tx_data`  in  `DATA_W`  next word to return.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding register is empty.
- `rx_data`  out  `DATA_W`  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `tx_underrun`  out  1  one-cycle pulse when a word starts with the holding register empty.
- `frame_err`  out  1  one-cycle pulse when `spi_csn` rises mid-word.
- `spi_busy`  out  1  frame in progress.
- `spi_csn`  in  1  chip select, active low.
- `spi_clk`  in  1  SPI clock from the master.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data.
- `spi_miso_oe`  out  1  MISO output enable. High only while the frame is active.

## Operation
- States:
  - IDLE to ACTIVE on the synchronized `spi_csn` falling edge.
  - ACTIVE to IDLE on the synchronized `spi_csn` rising edge.
  - `spi_busy` = (state == ACTIVE).
- Edge definitions:
  - Leading edge = `spi_clk` leaving its CPOL level.
  - Trailing edge = `spi_clk` returning to its CPOL level.
  - SPI clock edges are ignored in IDLE.
- CPHA=0:
  - Sample `spi_mosi` on the leading edge.
  - Shift `spi_miso` on the trailing edge.
  - The MSB is driven on `spi_miso` at word start.
- CPHA=1:
  - Shift on the leading edge. The MSB appears at the first leading edge.
  - Sample on the trailing edge.
- Word start:
  - Occurs at the `spi_csn` fall, and at each bit-counter wrap while `spi_csn` stays low (back-to-back words are supported).
  - The TX shift register loads from the holding register, which empties and raises `tx_ready`.
  - If the holding register is empty, the shift register loads 0 and `tx_underrun` pulses.
  - If `tx_valid` is accepted in the same cycle as word start, `tx_data` goes straight to the shift register and no underrun is flagged.
- Receive:
  - The bit counter counts 0 to `DATA_W`-1.
  - On the last sample, `rx_data` takes the shifted word, `rx_valid` pulses, and the counter wraps to 0.
- Holding register:
  - Written when `tx_valid & tx_ready`.
  - `tx_valid` is ignored while `tx_ready` is 0.
  - Contents are retained across frames and aborts.
- Abort:
  - Condition: `spi_csn` rises with the bit counter ≠ 0.
  - Pulse `frame_err`, discard the partial RX word, clear the counter and TX shift register, return to IDLE.
  - No `rx_valid` is produced.
- Mode handling: `spi_mode` changes while ACTIVE are ignored until the next `spi_csn` fall.
- Reset mid-frame:
  - All outputs and state return to reset values.
  - After reset release, the block waits for `spi_csn` to be seen high before it can enter ACTIVE. A frame already in progress is ignored.

## Timing
- Output reset values:
  - `spi_miso` = 0, `spi_miso_oe` = 0.
  - `tx_ready` = 1.
  - `rx_data` = 0.
  - `rx_valid`, `tx_underrun`, `frame_err`, `spi_busy` = 0.
- Edge detect latency: `SYNC_STAGES` + 1 `sys_clk` cycles from an SPI pin change to internal detection.
- `spi_miso` is registered and updates 1 cycle after the detected shift edge.
- `rx_valid` is asserted 1 cycle after the detected last sampling edge.
- Constraints:
  - `spi_clk` high and low times must each be ≥ 4 `sys_clk` cycles, i.e. `spi_clk` ≤ `sys_clk`/8.
  - `spi_csn` setup to the first edge and hold after the last edge must each be ≥ 4 `sys_clk` cycles.
- `spi_miso_oe` rises 1 cycle after the detected `spi_csn` fall and drops 1 cycle after the detected rise.
- `tx_ready` rises in the cycle after the holding register transfers at word start.

## Structure
- Package `spi_pkg`:
  - `SPI_MODE0`..`SPI_MODE3` constants.
  - `CPOL_BIT`/`CPHA_BIT` indices.
  - Default `DATA_W`.
  - State encoding (IDLE, ACTIVE).
- Sub-module `spi_in_sync`: a `SYNC_STAGES`-deep synchronizer with rise/fall pulse outputs. Instantiated once each for `spi_clk`, `spi_csn` and `spi_mosi`; the `spi_mosi` instance does not use its edge pulses.

## Test plan
- Mode 0, `sys_clk`/8: preload 16'hA55A, master sends 16'h1234 → `rx_data` = 16'h1234 with a single `rx_valid` pulse; master reads 16'hA55A.
- Modes 1, 2, 3: same exchange with 16'hC3E1/16'h0F0F → identical results in every mode, and `spi_miso` changes only on the specified edges.
- Two back-to-back words in one `spi_csn` frame, with the second `tx_data` given mid-first-word → two `rx_valid` pulses and both TX words returned in order, no underrun.
- No preload → master reads 16'h0000, `tx_underrun` pulses once at the `spi_csn` fall.
- `spi_csn` rises after 7 bits → `frame_err` pulses and there is no `rx_valid`. The next full frame of 16'hBEEF is received correctly.
- `sys_rst` asserted mid-word while `spi_csn` stays low → all outputs return to reset values and that frame is ignored. The next `spi_csn` cycle of 16'h5AA5 is received normally.
